pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and synchronous flush.
// A held entry is a control field plus a data field. An all-zero control field
// is a bubble.
// SKID=1 gives a two-entry skid buffer, so in_ready comes straight from a flop.
// SKID=0 gives a single entry, and in_ready is combinational from out_ready.
// stall_cnt is a saturating count of the cycles in which downstream
// back-pressure held a valid entry.
//
// state | meaning
// ------+-----------------------------------------------------------------
// EMPTY | nothing held; out_valid=0, out_ctrl forced to a bubble
// ONE   | one entry in main, presented downstream
// TWO   | main presented, second entry parked in skid; in_ready=0 (SKID=1)
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              drain;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and register load strobes. Flush overrides any accept or drain.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Without a skid buffer, in_ready already blocks this case.
            if (SKID != 0) begin
              state_nxt = TWO;
              load_skid = 1'b1;
            end
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output decode. An empty stage always presents a bubble control field.
  always_comb begin
    out_valid = (state != EMPTY);
    out_ctrl  = '0;
    if (state != EMPTY) begin
      out_ctrl = main_ctrl;
    end
  end

  assign out_data = main_data;

  // Entry registers. Flush clears only the control fields, so the data field
  // still holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Registered ready looks ahead at the next state. It stays low through
      // reset and rises on the first edge after reset is released.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= (state_nxt != TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Saturating back-pressure counter. Clear wins over increment, and flush
  // has no effect on the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
